alu_matrix_sequencer: RTL

ALU_MATRIX_SEQUENCER -- requirements
Module: alu_matrix_sequencer

---
 rtl/alu_matrix_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_matrix_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_matrix_sequencer
// Brief    : Loads a 2x2 A/B pair into the ALU matrix core, issues one op,
//            then reads R[0..3] back to the host one element at a time.
// Revision : 1.0 - initial release
// ============================================================================
module alu_matrix_sequencer #(
  parameter int OP_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic [5:0]  sel,
  output logic [31:0] eleIn,
  input  logic [31:0] eleOut
);

  localparam int                  C_WAIT_W    = (OP_WAIT > 1) ? $clog2(OP_WAIT) : 1;
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(OP_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_EXEC     = 4'd2,
    S_WAIT     = 4'd3,
    S_RD_ISSUE = 4'd4,
    S_RD_HOLD  = 4'd5,
    S_RD_CAP   = 4'd6,
    S_OUT      = 4'd7
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_k, w_k_nxt;
  logic [C_WAIT_W-1:0]   r_wait, w_wait_nxt;
  logic [1:0]            r_op, w_op_nxt;
  logic [5:0]            r_sel, w_sel_nxt;
  logic [31:0]           r_ele_in, w_ele_in_nxt;
  logic [31:0]           r_out_data, w_out_data_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic                  r_busy;
  logic                  w_cmd_ready;
  logic                  w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= 3'd0;
      r_wait      <= '0;
      r_op        <= 2'd0;
      r_sel       <= 6'd0;
      r_ele_in    <= 32'd0;
      r_out_data  <= 32'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_wait      <= w_wait_nxt;
      r_op        <= w_op_nxt;
      r_sel       <= w_sel_nxt;
      r_ele_in    <= w_ele_in_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_wait_nxt      = r_wait;
    w_op_nxt        = r_op;
    w_sel_nxt       = r_sel;
    w_ele_in_nxt    = r_ele_in;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_cmd_ready     = 1'b0;
    w_in_ready      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_sel_nxt   = 6'd0;
        if (cmd_valid) begin
          w_op_nxt    = cmd_op;
          w_k_nxt     = 3'd0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_sel_nxt    = {3'b000, r_k} + 6'd1;
          w_ele_in_nxt = in_data;
          w_k_nxt      = r_k + 3'd1;
          if (r_k == 3'd7) begin
            w_state_nxt = S_EXEC;
          end
        end else begin
          w_sel_nxt = 6'd0;
        end
      end
      S_EXEC: begin
        w_sel_nxt   = {4'b0100, r_op};
        w_wait_nxt  = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_sel_nxt = 6'd0;
        if (r_wait == C_WAIT_LAST) begin
          w_k_nxt     = 3'd0;
          w_state_nxt = S_RD_ISSUE;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_RD_ISSUE: begin
        w_sel_nxt   = {3'b100, r_k};
        w_state_nxt = S_RD_HOLD;
      end
      // Core has a two-edge read latency: issue, hold, then capture.
      S_RD_HOLD: begin
        w_state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_out_data_nxt  = eleOut;
        w_out_valid_nxt = 1'b1;
        w_sel_nxt       = 6'd0;
        w_state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (r_k == 3'd3) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_k_nxt     = r_k + 3'd1;
            w_state_nxt = S_RD_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = w_cmd_ready & ~reset;
  assign in_ready  = w_in_ready & ~reset;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign sel       = r_sel;
  assign eleIn     = r_ele_in;

endmodule
`default_nettype wire
